// File: rtl/multi_sig_gen.sv
// Multi-channel divided-clock test-signal generator with per-channel period-start strobe.
// Optional counted-burst mode is enabled by defining MULTI_SIG_GEN_BURST_EN.
module multi_sig_gen #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNT_W    = 21,
  parameter int unsigned DIV0     = 32000,
  parameter int unsigned DIV1     = 400000,
  parameter int unsigned DIV2     = 2000000,
  parameter int unsigned DIV3     = 8000,
  parameter int unsigned BURST_W  = 8
) (
  input  logic                    sysclk,
  input  logic                    reset,
  input  logic [CHANNELS-1:0]     en,
  input  logic [2*CHANNELS-1:0]   mode,
  input  logic [CHANNELS-1:0]     burst_start,
  input  logic [BURST_W-1:0]      burst_len,
  output logic [CHANNELS-1:0]     sig_out,
  output logic [CHANNELS-1:0]     period_tick,
  output logic [CHANNELS-1:0]     burst_busy
);

  // One extra bit so a divide of exactly 2^CNT_W is representable.
  localparam int unsigned DIV_W = CNT_W + 1;

  typedef logic [DIV_W-1:0] div_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam div_t P0 = div_t'(DIV0);
  localparam div_t P1 = div_t'(DIV1);
  localparam div_t P2 = div_t'(DIV2);
  localparam div_t P3 = div_t'(DIV3);

  function automatic div_t preset(input logic [1:0] m);
    case (m)
      2'b00:   return P0;
      2'b01:   return P1;
      2'b10:   return P2;
      default: return P3;
    endcase
  endfunction

  cnt_t                cnt_q [CHANNELS];
  cnt_t                cnt_d [CHANNELS];
  div_t                act_q [CHANNELS];
  div_t                act_d [CHANNELS];
  logic [CHANNELS-1:0] sig_q, sig_d;
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic [CHANNELS-1:0] busy_q;
  logic [CHANNELS-1:0] wrap;
  logic [CHANNELS-1:0] run;

  always_comb begin
    wrap = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      wrap[i] = ({1'b0, cnt_q[i]} == (act_q[i] - 1'b1));
    end
  end

  assign run = en | busy_q;

  // The active divide is reloaded only at the period boundary (or while idle),
  // which is what keeps mode changes free of runt or stretched periods.
  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    sig_d  = sig_q;
    tick_d = tick_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (run[i]) begin
        sig_d[i]  = ({1'b0, cnt_q[i]} < (act_q[i] >> 1));
        tick_d[i] = (cnt_q[i] == '0);
        if (wrap[i]) begin
          cnt_d[i] = '0;
          act_d[i] = preset(mode[2*i +: 2]);
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i]  = '0;
        sig_d[i]  = 1'b0;
        tick_d[i] = 1'b0;
        act_d[i]  = preset(mode[2*i +: 2]);
      end
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '{default: '0};
      act_q  <= '{default: P0};
      sig_q  <= '0;
      tick_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      sig_q  <= sig_d;
      tick_q <= tick_d;
    end
  end

`ifdef MULTI_SIG_GEN_BURST_EN
  logic [BURST_W-1:0]  rem_q [CHANNELS];
  logic [BURST_W-1:0]  rem_d [CHANNELS];
  logic [CHANNELS-1:0] busy_d;

  // Enable taking over a burst drops busy but leaves the counter untouched,
  // so the waveform carries on without a phase jump.
  always_comb begin
    rem_d  = rem_q;
    busy_d = busy_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (busy_q[i]) begin
        if (en[i]) begin
          busy_d[i] = 1'b0;
          rem_d[i]  = '0;
        end else if (wrap[i]) begin
          rem_d[i] = rem_q[i] - 1'b1;
          if (rem_q[i] == BURST_W'(1)) busy_d[i] = 1'b0;
        end
      end else if (!en[i] && burst_start[i] && (burst_len != '0)) begin
        rem_d[i]  = burst_len;
        busy_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rem_q  <= '{default: '0};
      busy_q <= '0;
    end else begin
      rem_q  <= rem_d;
      busy_q <= busy_d;
    end
  end
`else
  logic unused_burst;
  assign unused_burst = ^{burst_start, burst_len};
  assign busy_q       = '0;
`endif

  assign sig_out     = sig_q;
  assign period_tick = tick_q;
  assign burst_busy  = busy_q;

endmodule

// File: tb/tb_multi_sig_gen.sv
// Directed, table-driven bench for multi_sig_gen with small divides (4/6/5/2).
module tb_multi_sig_gen;

  logic       sysclk;
  logic       reset;
  logic [1:0] en;
  logic [3:0] mode;
  logic [1:0] burst_start;
  logic [7:0] burst_len;
  logic [1:0] sig_out;
  logic [1:0] period_tick;
  logic [1:0] burst_busy;

  int checks;
  int failures;

  multi_sig_gen #(
    .CHANNELS(2), .CNT_W(4), .DIV0(4), .DIV1(6), .DIV2(5), .DIV3(2), .BURST_W(8)
  ) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .en          (en),
    .mode        (mode),
    .burst_start (burst_start),
    .burst_len   (burst_len),
    .sig_out     (sig_out),
    .period_tick (period_tick),
    .burst_busy  (burst_busy)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [1:0] en;
    logic [3:0] mode;
    logic [1:0] sig;
    logic [1:0] tick;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [1:0] e, input logic [3:0] m,
                              input logic [1:0] s, input logic [1:0] t);
    vec_t v;
    v.en = e; v.mode = m; v.sig = s; v.tick = t;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] e, input logic [3:0] m,
                      input logic [1:0] bs, input logic [7:0] bl);
    @(negedge sysclk);
    en = e; mode = m; burst_start = bs; burst_len = bl;
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk_all(input string name, input logic [1:0] s,
                         input logic [1:0] t, input logic [1:0] b);
    chk({name, " sig"},  sig_out,     s);
    chk({name, " tick"}, period_tick, t);
    chk({name, " busy"}, burst_busy,  b);
  endtask

  initial begin
    logic [9:0] rst_pat;
    int         busy_cycles;
    checks = 0; failures = 0;
    reset = 1'b1; en = '0; mode = '0; burst_start = '0; burst_len = '0;

    // mode is {ch1, ch0}
    // ch0 mode 00: 1100 repeating
    add(2'b01, 4'b0000, 2'b01, 2'b01); add(2'b01, 4'b0000, 2'b01, 2'b00);
    add(2'b01, 4'b0000, 2'b00, 2'b00); add(2'b01, 4'b0000, 2'b00, 2'b00);
    add(2'b01, 4'b0000, 2'b01, 2'b01); add(2'b01, 4'b0000, 2'b01, 2'b00);
    add(2'b01, 4'b0000, 2'b00, 2'b00); add(2'b01, 4'b0000, 2'b00, 2'b00);
    // switch to mode 01 at cnt=1: finish 1100, then 111000
    add(2'b01, 4'b0000, 2'b01, 2'b01); add(2'b01, 4'b0001, 2'b01, 2'b00);
    add(2'b01, 4'b0001, 2'b00, 2'b00); add(2'b01, 4'b0001, 2'b00, 2'b00);
    add(2'b01, 4'b0001, 2'b01, 2'b01); add(2'b01, 4'b0001, 2'b01, 2'b00);
    add(2'b01, 4'b0001, 2'b01, 2'b00); add(2'b01, 4'b0001, 2'b00, 2'b00);
    add(2'b01, 4'b0001, 2'b00, 2'b00); add(2'b01, 4'b0001, 2'b00, 2'b00);
    // odd divide 5: 11000 twice
    add(2'b00, 4'b0010, 2'b00, 2'b00);
    for (int r = 0; r < 2; r++) begin
      add(2'b01, 4'b0010, 2'b01, 2'b01); add(2'b01, 4'b0010, 2'b01, 2'b00);
      add(2'b01, 4'b0010, 2'b00, 2'b00); add(2'b01, 4'b0010, 2'b00, 2'b00);
      add(2'b01, 4'b0010, 2'b00, 2'b00);
    end
    // minimum divide 2: 10
    add(2'b00, 4'b0011, 2'b00, 2'b00);
    add(2'b01, 4'b0011, 2'b01, 2'b01); add(2'b01, 4'b0011, 2'b00, 2'b00);
    add(2'b01, 4'b0011, 2'b01, 2'b01); add(2'b01, 4'b0011, 2'b00, 2'b00);
    // ch1 mode 01 with ch0 mode 00; ch0 dropped while high
    add(2'b00, 4'b0100, 2'b00, 2'b00);
    add(2'b11, 4'b0100, 2'b11, 2'b11); add(2'b10, 4'b0100, 2'b10, 2'b00);
    add(2'b10, 4'b0100, 2'b10, 2'b00); add(2'b10, 4'b0100, 2'b00, 2'b00);
    add(2'b10, 4'b0100, 2'b00, 2'b00); add(2'b10, 4'b0100, 2'b00, 2'b00);
    add(2'b10, 4'b0100, 2'b10, 2'b10); add(2'b00, 4'b0100, 2'b00, 2'b00);

    // reset state
    repeat (2) @(posedge sysclk);
    #1;
    chk_all("reset", 2'b00, 2'b00, 2'b00);
    @(negedge sysclk);
    reset = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].en, vecs[k].mode, 2'b00, 8'd0);
      chk_all($sformatf("vec%0d", k), vecs[k].sig, vecs[k].tick, 2'b00);
    end

    // asynchronous reset mid-run
    step(2'b11, 4'b0000, 2'b00, 8'd0);
    chk("prerst sig", sig_out, 2'b11);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_rst", 2'b00, 2'b00, 2'b00);
    @(negedge sysclk);
    en = 2'b00; mode = 4'b0001;
    @(negedge sysclk);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step(2'b00, 4'b0001, 2'b00, 8'd0);
      chk_all($sformatf("post_rst%0d", k), 2'b00, 2'b00, 2'b00);
    end

    // active divide restarts at DIV0 after reset regardless of idle mode tracking
    @(negedge sysclk);
    reset = 1'b1;
    @(negedge sysclk);
    reset = 1'b0; en = 2'b01; mode = 4'b0001;
    @(posedge sysclk);
    #1;
    rst_pat = 10'b1100111000;
    chk("div0_after_rst0 sig", sig_out, {1'b0, rst_pat[9]});
    for (int k = 1; k < 10; k++) begin
      step(2'b01, 4'b0001, 2'b00, 8'd0);
      chk($sformatf("div0_after_rst%0d sig", k), sig_out, {1'b0, rst_pat[9-k]});
    end
    step(2'b00, 4'b0000, 2'b00, 8'd0);
    chk_all("idle", 2'b00, 2'b00, 2'b00);

`ifdef MULTI_SIG_GEN_BURST_EN
    // three-period burst, second pulse while busy ignored
    step(2'b00, 4'b0000, 2'b01, 8'd3);
    chk_all("burst_acc", 2'b00, 2'b00, 2'b01);
    busy_cycles = burst_busy[0] ? 1 : 0;
    for (int k = 0; k < 12; k++) begin
      step(2'b00, 4'b0000, (k == 2) ? 2'b01 : 2'b00, 8'd3);
      chk_all($sformatf("burst%0d", k), {1'b0, (k % 4) < 2}, {1'b0, (k % 4) == 0},
              {1'b0, k < 11});
      if (burst_busy[0]) busy_cycles++;
    end
    chk("burst_busy_cycles", busy_cycles, 12);
    for (int k = 0; k < 2; k++) begin
      step(2'b00, 4'b0000, 2'b00, 8'd3);
      chk_all($sformatf("burst_done%0d", k), 2'b00, 2'b00, 2'b00);
    end
    // zero-length burst request
    step(2'b00, 4'b0000, 2'b01, 8'd0);
    chk_all("burst_len0", 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 2; k++) begin
      step(2'b00, 4'b0000, 2'b00, 8'd0);
      chk_all($sformatf("burst_len0_%0d", k), 2'b00, 2'b00, 2'b00);
    end
    // enable takes over a running burst seamlessly
    step(2'b00, 4'b0000, 2'b01, 8'd2);
    chk_all("takeover_acc", 2'b00, 2'b00, 2'b01);
    for (int k = 0; k < 12; k++) begin
      step((k < 2) ? 2'b00 : 2'b01, 4'b0000, 2'b00, 8'd2);
      chk_all($sformatf("takeover%0d", k), {1'b0, (k % 4) < 2}, {1'b0, (k % 4) == 0},
              {1'b0, k < 2});
    end
    step(2'b00, 4'b0000, 2'b00, 8'd0);
    chk_all("takeover_stop", 2'b00, 2'b00, 2'b00);
`else
    busy_cycles = 0;
    step(2'b00, 4'b0000, 2'b11, 8'd3);
    chk_all("noburst_acc", 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 4; k++) begin
      step(2'b00, 4'b0000, 2'b00, 8'd3);
      chk_all($sformatf("noburst%0d", k), 2'b00, 2'b00, 2'b00);
      if (burst_busy != 2'b00) busy_cycles++;
    end
    chk("noburst_busy_cycles", busy_cycles, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
